// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SERIAL_ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell; port order (sum, carry, a, b, cin).
module FullAdder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle through a FullAdder, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic            carry_q;
  logic            fa_sum;
  logic            fa_carry;

  FullAdder u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (acc_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q)
  );

  // acc_q doubles as operand-A and result shift register: the sum bit fills
  // the MSB vacated by each right shift, so after WIDTH steps it holds a+b+cin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc_q    <= a;
            b_q      <= b;
            carry_q  <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_q   <= {fa_sum, acc_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= {fa_sum, acc_q[WIDTH-1:1]};
            cout      <= fa_carry;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB
            ovf       <= carry_q ^ fa_carry;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random and WIDTH=4 exhaustive.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, cin8, co8, bz8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, ov4, or4, cin4, co4, bz4;
  logic [3:0] a4, b4, s4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       of8, of4;
`endif

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of8)
`endif
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(bz4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of4)
`endif
  );

  int nchecks = 0;
  int nerrors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic        bz;
    logic        co;
    logic        of;
    logic [31:0] s;
  } obs_t;

  function automatic obs_t get_out(input int idx);
    obs_t o;
    if (idx == 0) begin
      o.ir = ir8; o.ov = ov8; o.bz = bz8; o.co = co8; o.s = 32'(s8);
`ifdef SERIAL_ADDER_OVF_EN
      o.of = of8;
`else
      o.of = 1'b0;
`endif
    end else begin
      o.ir = ir4; o.ov = ov4; o.bz = bz4; o.co = co4; o.s = 32'(s4);
`ifdef SERIAL_ADDER_OVF_EN
      o.of = of4;
`else
      o.of = 1'b0;
`endif
    end
    return o;
  endfunction

  task automatic set_in(input int idx, input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic ordy);
    if (idx == 0) begin
      iv8 = iv; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; or8 = ordy;
    end else begin
      iv4 = iv; a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; or4 = ordy;
    end
  endtask

  task automatic noise(input int idx, input bit en);
    set_in(idx, en ? 1'b1 : 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Reference: plain integer addition, signed overflow from operand/result sign bits.
  task automatic txn(input int idx, input logic [31:0] a, input logic [31:0] b, input logic cin,
                     input int hold, input bit nz);
    int unsigned    w;
    longint unsigned mask, full, es;
    logic           ec, eo, sa, sb;
    obs_t           o;
    int             n;
    w    = (idx == 0) ? 8 : 4;
    mask = (64'd1 << w) - 1;
    full = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
    es   = full & mask;
    ec   = 1'(full >> w);
    sa   = 1'((longint'(a) >> (w - 1)) & 1);
    sb   = 1'((longint'(b) >> (w - 1)) & 1);
    eo   = (sa == sb) && (1'((es >> (w - 1)) & 1) != sa);

    set_in(idx, 1'b1, a, b, cin, 1'b0);
    o = get_out(idx);
    check("in_ready_idle", o.ir, 1);
    @(posedge clk); @(negedge clk);
    noise(idx, nz);
    o = get_out(idx);
    check("busy_run", o.bz, 1);
    check("in_ready_run", o.ir, 0);

    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
      o = get_out(idx);
      noise(idx, nz);
    end while (!o.ov && n < int'(w) + 4);
    check("latency", 64'(n), 64'(w));

    for (int h = 0; h < hold; h++) begin
      check("hold_valid", o.ov, 1);
      check("hold_sum", o.s, es);
      check("hold_cout", o.co, ec);
      @(posedge clk); @(negedge clk);
      o = get_out(idx);
      noise(idx, nz);
    end
    check("in_ready_done", o.ir, 0);
    check("sum", o.s, es);
    check("cout", o.co, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", o.of, eo);
`else
    if (eo) check("busy_done", o.bz, 1);
`endif
    set_in(idx, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    set_in(idx, 1'b0, 0, 0, 1'b0, 1'b0);
    o = get_out(idx);
    check("valid_drop", o.ov, 0);
    check("ready_back", o.ir, 1);
    check("sum_held", o.s, es);
  endtask

  obs_t ro;

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 0, 0, 1'b0, 1'b0);
    set_in(1, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ro = get_out(i);
      check("rst_ready", ro.ir, 1);
      check("rst_valid", ro.ov, 0);
      check("rst_busy", ro.bz, 0);
      check("rst_sum", ro.s, 0);
      check("rst_cout", ro.co, 0);
    end
    rst_n = 1'b1;

    txn(0, 32'h03, 32'h05, 1'b0, 0, 0);
    txn(0, 32'hFF, 32'h01, 1'b0, 0, 0);
    txn(0, 32'h7F, 32'h01, 1'b0, 0, 0);
    txn(0, 32'h80, 32'h80, 1'b0, 0, 0);
    txn(0, 32'hFF, 32'hFF, 1'b1, 5, 1);
    txn(0, 32'h12, 32'h34, 1'b1, 5, 1);

    // reset after bits 0..3 have been processed
    set_in(0, 1'b1, 32'hA5, 32'h3C, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    set_in(0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    ro = get_out(0);
    check("abort_ready", ro.ir, 1);
    check("abort_valid", ro.ov, 0);
    check("abort_busy", ro.bz, 0);
    check("abort_sum", ro.s, 0);
    check("abort_cout", ro.co, 0);
    txn(0, 32'hA5, 32'h3C, 1'b1, 1, 0);

    for (int i = 0; i < 40; i++)
      txn(0, $urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)));

    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int cv = 0; cv < 2; cv++)
          txn(1, 32'(av), 32'(bv), 1'(cv), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
